// File: rtl/bf_result_checker_if.sv
// Read-side bus between the result checker and the output/expected memories,
// plus the monitored output-memory write enable.
interface bf_result_checker_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 13
);
  logic              om_we;
  logic [ADDR_W-1:0] om_rd_addr;
  logic [DATA_W-1:0] om_rd_data;
  logic [ADDR_W-1:0] exp_rd_addr;
  logic [DATA_W-1:0] exp_rd_data;

  modport master (
    input  om_we, om_rd_data, exp_rd_data,
    output om_rd_addr, exp_rd_addr
  );

  modport slave (
    output om_we, om_rd_data, exp_rd_data,
    input  om_rd_addr, exp_rd_addr
  );
endinterface

// File: rtl/bf_result_checker.sv
// Waits for the Bellman-Ford engine to go quiet, then sweeps a window of output
// memory against expected memory and reports mismatch count, first bad address, pass.
module bf_result_checker #(
  parameter int DATA_W         = 16,
  parameter int ADDR_W         = 13,
  parameter int NUM_WORDS      = 256,
  parameter int BASE_ADDR      = 0,
  parameter int QUIET_CYCLES   = 32,
  parameter int TIMEOUT_CYCLES = 100000,
  parameter int CNT_W          = 16
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 start,
  input  logic [DATA_W-1:0]    cmp_mask,
  bf_result_checker_if.master  mem,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic                 timeout,
  output logic                 late_write,
  output logic [CNT_W-1:0]     mismatch_count,
  output logic [ADDR_W-1:0]    first_bad_addr
);

  localparam int QW = $clog2(QUIET_CYCLES + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int SW = $clog2(NUM_WORDS + 1);

  localparam logic [QW-1:0]     QUIET_LAST = QW'(QUIET_CYCLES - 1);
  localparam logic [TW-1:0]     TO_LAST    = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [SW-1:0]     SCAN_LAST  = SW'(NUM_WORDS - 1);
  localparam logic [ADDR_W-1:0] BASE       = ADDR_W'(BASE_ADDR);
  localparam logic [CNT_W-1:0]  CNT_MAX    = '1;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_SCAN, S_DONE} state_t;

  state_t            r_state;
  state_t            w_next;
  logic [QW-1:0]     r_quiet_cnt;
  logic [TW-1:0]     r_to_cnt;
  logic [SW-1:0]     r_scan_cnt;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_mask;
  logic              r_timeout;
  logic              r_late;
  logic [CNT_W-1:0]  r_cnt;
  logic [ADDR_W-1:0] r_first;

  logic w_quiet_hit;
  logic w_to_hit;
  logic w_scan_last;
  logic w_bad;

  // Quiet is judged on this cycle's om_we so the transition lands on the
  // QUIET_CYCLES-th consecutive idle cycle; quiet takes priority over timeout.
  assign w_quiet_hit = !mem.om_we && (r_quiet_cnt == QUIET_LAST);
  assign w_to_hit    = (r_to_cnt == TO_LAST);
  assign w_scan_last = (r_scan_cnt == SCAN_LAST);
  assign w_bad       = |((mem.om_rd_data ^ mem.exp_rd_data) & r_mask);

  always_ff @(posedge clock) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE, S_DONE: if (start) w_next = S_WAIT;
      S_WAIT: begin
        if (w_quiet_hit)   w_next = S_SCAN;
        else if (w_to_hit) w_next = S_DONE;
      end
      S_SCAN: if (w_scan_last) w_next = S_DONE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_quiet_cnt <= '0;
      r_to_cnt    <= '0;
      r_scan_cnt  <= '0;
      r_addr      <= BASE;
      r_mask      <= '0;
      r_timeout   <= 1'b0;
      r_late      <= 1'b0;
      r_cnt       <= '0;
      r_first     <= '0;
    end else begin
      unique case (r_state)
        S_IDLE, S_DONE: begin
          if (start) begin
            r_quiet_cnt <= '0;
            r_to_cnt    <= '0;
            r_scan_cnt  <= '0;
            r_mask      <= cmp_mask;
            r_timeout   <= 1'b0;
            r_late      <= 1'b0;
            r_cnt       <= '0;
            r_first     <= '0;
          end
        end
        S_WAIT: begin
          r_quiet_cnt <= mem.om_we ? '0 : r_quiet_cnt + 1'b1;
          r_to_cnt    <= r_to_cnt + 1'b1;
          if (w_quiet_hit) begin
            r_addr     <= BASE;
            r_scan_cnt <= '0;
          end else if (w_to_hit) begin
            r_timeout  <= 1'b1;
          end
        end
        S_SCAN: begin
          r_addr     <= r_addr + 1'b1;
          r_scan_cnt <= r_scan_cnt + 1'b1;
          if (mem.om_we) r_late <= 1'b1;
          if (w_bad) begin
            if (r_cnt != CNT_MAX) r_cnt <= r_cnt + 1'b1;
            if (r_cnt == '0)      r_first <= r_addr;
          end
        end
        default: ;
      endcase
    end
  end

  assign mem.om_rd_addr  = r_addr;
  assign mem.exp_rd_addr = r_addr;

  assign busy           = (r_state == S_WAIT) || (r_state == S_SCAN);
  assign done           = (r_state == S_DONE);
  assign pass           = done && (r_cnt == '0) && !r_timeout && !r_late;
  assign timeout        = r_timeout;
  assign late_write     = r_late;
  assign mismatch_count = r_cnt;
  assign first_bad_addr = r_first;

endmodule

// File: tb/tb_bf_result_checker.sv
// Bench for bf_result_checker: directed scenarios plus randomized om_we patterns,
// memory corruptions and masks, checked every cycle against a run-level model.
module tb_bf_result_checker;

  localparam int DW    = 16;
  localparam int AW    = 13;
  localparam int NW    = 8;
  localparam int BASE  = 'h1FFE;
  localparam int Q     = 4;
  localparam int T     = 50;
  localparam int CW    = 2;
  localparam int MEMSZ = 8192;
  localparam int MAXK  = 128;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic          reset;
  logic          start;
  logic [DW-1:0] cmp_mask;
  logic          om_we_r;
  logic          busy, done, pass, timeout, late_write;
  logic [CW-1:0] mismatch_count;
  logic [AW-1:0] first_bad_addr;

  logic [DW-1:0] om_mem  [MEMSZ];
  logic [DW-1:0] exp_mem [MEMSZ];

  bf_result_checker_if #(.DATA_W(DW), .ADDR_W(AW)) mif ();

  assign mif.om_we       = om_we_r;
  assign mif.om_rd_data  = om_mem[mif.om_rd_addr];
  assign mif.exp_rd_data = exp_mem[mif.exp_rd_addr];

  bf_result_checker #(
    .DATA_W(DW), .ADDR_W(AW), .NUM_WORDS(NW), .BASE_ADDR(BASE),
    .QUIET_CYCLES(Q), .TIMEOUT_CYCLES(T), .CNT_W(CW)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .start          (start),
    .cmp_mask       (cmp_mask),
    .mem            (mif),
    .busy           (busy),
    .done           (done),
    .pass           (pass),
    .timeout        (timeout),
    .late_write     (late_write),
    .mismatch_count (mismatch_count),
    .first_bad_addr (first_bad_addr)
  );

  int total = 0;
  int bad   = 0;

  // om_we value driven in run-relative cycle k (cycle 0 carries the start pulse)
  bit we_pat [MAXK];
  int extra_start = -1;

  // model results for the current run
  bit m_scan, m_to, m_late;
  int m_S, m_E, m_cnt, m_first;
  int m_hold, m_hold_prev;

  int cur_k;
  bit mon_on    = 1'b0;
  bit abort_chk = 1'b0;
  int d_obs;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s (k=%0d): got %0h want %0h", nm, cur_k, act, exp);
    end
  endtask

  function automatic int waddr(input int i);
    return (BASE + i) % MEMSZ;
  endfunction

  // Run-level model: find the first window of Q idle cycles inside the
  // T-cycle waiting budget, then score the NUM_WORDS-word sweep.
  function automatic void model(input logic [DW-1:0] mask);
    bit found;
    bit quiet;
    int a;
    found = 1'b0;
    m_scan = 1'b0; m_to = 1'b0; m_late = 1'b0; m_cnt = 0; m_first = 0; m_S = 0;
    for (int j = Q; j <= T && !found; j++) begin
      quiet = 1'b1;
      for (int q = j - Q + 1; q <= j; q++) if (we_pat[q]) quiet = 1'b0;
      if (quiet) begin
        found = 1'b1;
        m_S = j + 1;
      end
    end
    if (found) begin
      m_scan = 1'b1;
      m_E = m_S + NW;
      for (int i = 0; i < NW; i++) begin
        a = waddr(i);
        if (we_pat[m_S + i]) m_late = 1'b1;
        if (((om_mem[a] ^ exp_mem[a]) & mask) != 0) begin
          if (m_cnt == 0) m_first = a;
          m_cnt++;
        end
      end
      if (m_cnt > (1 << CW) - 1) m_cnt = (1 << CW) - 1;
      m_hold = waddr(NW);
    end else begin
      m_to = 1'b1;
      m_E = T + 1;
    end
  endfunction

  always @(negedge clock) begin
    int ea;
    if (mon_on) begin
      if (abort_chk) begin
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_pass", pass, 0);
        chk("rst_timeout", timeout, 0);
        chk("rst_late", late_write, 0);
        chk("rst_count", mismatch_count, 0);
        chk("rst_first", first_bad_addr, 0);
        chk("rst_addr", mif.om_rd_addr, BASE);
      end else begin
        if (done === 1'b1 && d_obs < 0) d_obs = cur_k;
        chk("busy", busy, cur_k < m_E);
        chk("done", done, cur_k >= m_E);
        if (m_scan && cur_k >= m_S && cur_k < m_E) ea = waddr(cur_k - m_S);
        else if (cur_k >= m_E)                       ea = m_hold;
        else                                         ea = m_hold_prev;
        chk("om_rd_addr", mif.om_rd_addr, ea);
        chk("exp_rd_addr", mif.exp_rd_addr, ea);
        if (cur_k >= m_E) begin
          chk("mismatch_count", mismatch_count, m_cnt);
          chk("first_bad_addr", first_bad_addr, m_first);
          chk("timeout", timeout, m_to);
          chk("late_write", late_write, m_late);
          chk("pass", pass, (m_cnt == 0) && !m_to && !m_late);
        end
      end
    end
  end

  task automatic clear_we();
    for (int k = 0; k < MAXK; k++) we_pat[k] = 1'b0;
  endtask

  task automatic restore();
    for (int i = 0; i < NW; i++) exp_mem[waddr(i)] = om_mem[waddr(i)];
  endtask

  // abort_at > 0 asserts reset during that run-relative cycle
  task automatic run(input logic [DW-1:0] mask, input int abort_at);
    m_hold_prev = m_hold;
    model(mask);
    d_obs = -1;
    @(posedge clock); #1;
    for (int k = 0; k <= m_E + 1; k++) begin
      if (k > 0) begin
        @(posedge clock); #1;
      end
      cur_k     = k;
      start     = (k == 0) || (k == extra_start);
      cmp_mask  = (k == 0) ? mask : ~mask;
      om_we_r   = we_pat[k];
      reset     = (abort_at > 0) && (k == abort_at);
      mon_on    = (k >= 1);
      abort_chk = (abort_at > 0) && (k == abort_at + 1);
      if (abort_chk) begin
        @(negedge clock); #1;
        break;
      end
    end
    @(posedge clock); #1;
    mon_on = 1'b0; abort_chk = 1'b0; start = 1'b0; om_we_r = 1'b0; reset = 1'b0;
    if (abort_at > 0) m_hold = BASE;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [DW-1:0] mask;
    int mode, n;
    reset = 1'b1; start = 1'b0; cmp_mask = '0; om_we_r = 1'b0; cur_k = 0;
    for (int a = 0; a < MEMSZ; a++) begin
      om_mem[a]  = DW'($urandom);
      exp_mem[a] = om_mem[a];
    end
    clear_we();
    m_hold = BASE;
    repeat (3) @(posedge clock);
    @(negedge clock);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_pass", pass, 0);
    chk("reset_count", mismatch_count, 0);
    chk("reset_first", first_bad_addr, 0);
    chk("reset_addr", mif.om_rd_addr, BASE);
    @(posedge clock); #1;
    reset = 1'b0;
    repeat (5) @(posedge clock);

    // silent engine, identical memories: done at 1 + Q + NW
    clear_we();
    run(16'hFFFF, 0);
    chk("silent_done_cycle", d_obs, 13);
    chk("silent_pass", pass, 1);

    // om_we pulses at 3,6,9 (plus an ignored start): scan from 14, done at 22
    clear_we();
    we_pat[3] = 1'b1; we_pat[6] = 1'b1; we_pat[9] = 1'b1;
    extra_start = 5;
    run(16'hFFFF, 0);
    extra_start = -1;
    chk("pulse_done_cycle", d_obs, 22);
    chk("pulse_pass", pass, 1);

    // words 3 and 6 differ (0x0001 and 0x0004 after the wrap)
    clear_we();
    exp_mem[waddr(3)] ^= 16'h0101;
    exp_mem[waddr(6)] ^= 16'h8000;
    run(16'hFFFF, 0);
    chk("two_bad_count", mismatch_count, 2);
    chk("two_bad_first", first_bad_addr, 13'h0001);
    chk("two_bad_pass", pass, 0);
    restore();

    // word 3 differs only in bit 15
    exp_mem[waddr(3)] ^= 16'h8000;
    run(16'h7FFF, 0);
    chk("mask7fff_count", mismatch_count, 0);
    chk("mask7fff_pass", pass, 1);
    run(16'hFFFF, 0);
    chk("maskffff_count", mismatch_count, 1);
    chk("maskffff_first", first_bad_addr, 13'h0001);
    restore();

    // om_we toggling every cycle never goes quiet: timeout 50 cycles after entry
    clear_we();
    for (int k = 1; k < MAXK; k++) we_pat[k] = k[0];
    run(16'hFFFF, 0);
    chk("timeout_done_cycle", d_obs, 51);
    chk("timeout_flag", timeout, 1);
    chk("timeout_pass", pass, 0);

    // write during the scan (plus an ignored start mid-scan)
    clear_we();
    we_pat[7] = 1'b1;
    extra_start = 6;
    run(16'hFFFF, 0);
    extra_start = -1;
    chk("late_flag", late_write, 1);
    chk("late_count", mismatch_count, 0);
    chk("late_pass", pass, 0);

    // every word wrong: 2-bit counter saturates at 3
    clear_we();
    for (int i = 0; i < NW; i++) exp_mem[waddr(i)] ^= 16'h0001;
    run(16'hFFFF, 0);
    chk("sat_count", mismatch_count, 3);
    chk("sat_first", first_bad_addr, 13'h1FFE);
    restore();

    // reset mid-scan after one mismatch, then a clean repeat
    clear_we();
    exp_mem[waddr(1)] ^= 16'h0010;
    exp_mem[waddr(4)] ^= 16'h0010;
    run(16'hFFFF, 8);
    run(16'hFFFF, 0);
    chk("rerun_count", mismatch_count, 2);
    chk("rerun_first", first_bad_addr, 13'h1FFF);
    chk("rerun_done_cycle", d_obs, 13);
    restore();

    for (int r = 0; r < 20; r++) begin
      clear_we();
      mode = $urandom_range(0, 3);
      if (mode == 0) begin
        for (int k = 1; k < MAXK; k++) we_pat[k] = 1'($urandom_range(0, 1));
      end else begin
        n = $urandom_range(0, 4);
        for (int p = 0; p < n; p++) we_pat[$urandom_range(1, 30)] = 1'b1;
        if ($urandom_range(0, 2) == 0) we_pat[$urandom_range(31, 45)] = 1'b1;
      end
      for (int i = 0; i < NW; i++)
        if ($urandom_range(0, 3) == 0) exp_mem[waddr(i)] ^= DW'(1 << $urandom_range(0, 15));
      mask = ($urandom_range(0, 1) == 1) ? 16'hFFFF : DW'($urandom);
      run(mask, 0);
      restore();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
